hazard_scoreboard: RTL

- Parametrised successor to the pipeline hazard unit.
- Replaces fixed-stage rsel/writeReg comparison with a per-register countdown scoreboard, so results can have variable latency (ALU, load, multi-cycle ops).
- Adds a dcache-miss wait FSM and a multi-cycle flush sequencer for taken branches and jumps.
- Sits beside the decode stage: it decides issue stall and IF/ID and ID/EX flush for the whole pipeline.

---
 rtl/hazard_scoreboard_pkg.sv | 24 ++
 rtl/hazard_sb_entry.sv | 35 +++
 rtl/hazard_scoreboard.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register select, latency, FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The typedefs below describe the default build (32 registers, 3-bit
// latency). Parametrised modules size their own buses from their parameters.
package hazard_scoreboard_pkg;

  localparam int HZ_NREGS         = 32;
  localparam int HZ_LAT_W         = 3;
  localparam int HZ_FLUSH_CYC_MAX = 7;
  // Wide enough to hold HZ_FLUSH_CYC_MAX-1.
  localparam int HZ_FCNT_W        = 3;

  typedef logic [$clog2(HZ_NREGS)-1:0] regsel_t;
  typedef logic [HZ_LAT_W-1:0]         lat_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: countdown of cycles until a pending register write is readable.
// Latency: load visible on count one edge after load; decrements one per advancing edge.
// Backpressure: advance=0 freezes the counter; load always wins over decrement.
//
// Ports:
//   clk, rst        pipeline clock, asynchronous active-high reset
//   load, load_val  start tracking a new write with load_val cycles to go
//   advance         let a nonzero count step down this edge
//   count, busy     current countdown and (count != 0)
module hazard_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             advance,
  output logic [LAT_W-1:0] count,
  output logic             busy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      // A newer write to the same register supersedes the one in flight.
      count <= load_val;
    end else if (advance && (count != '0)) begin
      count <= count - LAT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard unit: per-register countdown scoreboard, dcache-miss wait and redirect flush.
// Latency: stall/flush are combinational from the current inputs; scoreboard updates on the next edge.
// Backpressure: stall freezes PC/IF/ID/ID/EX; a dcache miss freezes the scoreboard; redirect squashes issue.
//
// Ports:
//   CLK, RST                 pipeline clock, asynchronous active-high reset
//   issue_valid              decode holds a valid instruction
//   rsel1/rsel2, use1/use2   source registers and whether each is read
//   wsel, wen, wlat          destination register, write enable, cycles until readable
//   redirect                 taken branch / jump resolved (level)
//   dmem_req, dhit           MEM stage request outstanding, dcache completes this cycle
//   stall, flush             pipeline freeze and IF/ID + ID/EX squash
//   busy                     per-register pending-write vector (bit 0 always 0)
//   fwd1, fwd2               operand comes from the forward path
//
// Build option: define HAZARD_SCOREBOARD_FWD_EN to treat a count of 1 as
// "result on the forward path": such a source no longer stalls and raises
// fwdN instead. Without it, fwd1/fwd2 are tied low.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int LAT_W     = 3,
  parameter int FLUSH_CYC = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] rsel1,
  input  logic [$clog2(NREGS)-1:0] rsel2,
  input  logic                     use1,
  input  logic                     use2,
  input  logic [$clog2(NREGS)-1:0] wsel,
  input  logic                     wen,
  input  logic [LAT_W-1:0]         wlat,
  input  logic                     redirect,
  input  logic                     dmem_req,
  input  logic                     dhit,
  output logic                     stall,
  output logic                     flush,
  output logic [NREGS-1:0]         busy,
  output logic                     fwd1,
  output logic                     fwd2
);

  localparam int SW = $clog2(NREGS);

  // ------------------------------------------------------------------
  // Scoreboard storage
  // ------------------------------------------------------------------
  logic [LAT_W-1:0] cnt [NREGS];

  hz_state_t             state;
  logic [HZ_FCNT_W-1:0]  fcnt;

  logic mem_stall;
  logic src1_live, src2_live;
  logic hz1, hz2;
  logic flush_now;
  logic accept;
  logic advance;
  logic track;

  // Register 0 is hardwired zero: never pending, never tracked.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  // wlat == 0 means the result is readable at once, so nothing is recorded
  // (and an entry already counting for that register is left alone).
  assign track = accept & wen & (wlat != '0);

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    hazard_sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk      (CLK),
      .rst      (RST),
      .load     (track & (wsel == SW'(r))),
      .load_val (wlat),
      .advance  (advance),
      .count    (cnt[r]),
      .busy     (busy[r])
    );
  end

  // ------------------------------------------------------------------
  // Source operand lookup
  // ------------------------------------------------------------------
  assign src1_live = use1 & (rsel1 != '0);
  assign src2_live = use2 & (rsel2 != '0);

`ifdef HAZARD_SCOREBOARD_FWD_EN
  // Count 1 means the producer is in the stage that feeds the bypass
  // network, so only longer countdowns have to hold issue.
  assign hz1  = src1_live & (cnt[rsel1] > LAT_W'(1));
  assign hz2  = src2_live & (cnt[rsel2] > LAT_W'(1));
  assign fwd1 = src1_live & (cnt[rsel1] == LAT_W'(1));
  assign fwd2 = src2_live & (cnt[rsel2] == LAT_W'(1));
`else
  assign hz1  = src1_live & (cnt[rsel1] != '0);
  assign hz2  = src2_live & (cnt[rsel2] != '0);
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Stall / flush / accept
  // ------------------------------------------------------------------
  // The miss stall covers both the first cycle of a miss (still in RUN) and
  // the whole MEM_WAIT stay, including the dhit cycle that ends it.
  assign mem_stall = (state == MEM_WAIT) | (dmem_req & ~dhit);

  assign stall = mem_stall | (issue_valid & (hz1 | hz2));

  // A miss outranks a redirect: the redirect is held by its source and
  // picked up again once the pipeline is back in RUN.
  assign flush_now = (state == RUN) & redirect & ~mem_stall;
  assign flush     = flush_now | (state == FLUSH);

  // Redirect outranks issue, so an instruction squashed this cycle never
  // reaches the scoreboard.
  assign accept  = issue_valid & ~stall & ~flush;

  // In-flight results keep retiring during a flush; only a miss freezes them.
  assign advance = ~mem_stall;

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  // fcnt counts the FLUSH cycles still to go after the current one, so
  // FLUSH lasts FLUSH_CYC cycles after the redirect cycle itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req & ~dhit) begin
            state <= MEM_WAIT;
          end else if (redirect) begin
            state <= FLUSH;
            fcnt  <= HZ_FCNT_W'(FLUSH_CYC - 1);
          end
        end
        MEM_WAIT: begin
          if (dhit) begin
            state <= RUN;
          end
        end
        FLUSH: begin
          if (fcnt == '0) begin
            state <= RUN;
          end else begin
            fcnt <= fcnt - HZ_FCNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          fcnt  <= '0;
        end
      endcase
    end
  end

endmodule
